// File: rtl/coeff_bank_loader_pkg.sv
// Shared definitions for the FIR coefficient bank loader: FSM states,
// default widths, tap-count derivation and the symmetric mirror index.
package coeff_bank_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_DATA_WIDTH = 18;

    // Number of taps held by a bank addressed with aw bits.
    function automatic int unsigned calcNtaps(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Mirrored tap index used by linear-phase (symmetric) coefficient sets.
    function automatic int unsigned mirrorIdx(input int unsigned aw, input int unsigned k);
        return calcNtaps(aw) - 32'd1 - k;
    endfunction

endpackage

// File: rtl/coeff_bank_loader_stage.sv
// Local staging register file: one synchronous write port used while a set
// is collected, one combinational read port used while the set is committed.
// Contents are deliberately not reset; stale entries are never read.
module coeff_stage_regs
    import coeff_bank_loader_pkg::*;
#(
    parameter int unsigned addrWidth = DEF_ADDR_WIDTH,
    parameter int unsigned dataWidth = DEF_DATA_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_wrEn,
    input  logic [addrWidth-1:0] i_wrAddr,
    input  logic [dataWidth-1:0] i_wrData,
    input  logic [addrWidth-1:0] i_rdAddr,
    output logic [dataWidth-1:0] o_rdData
);

    localparam int unsigned NTAPS = calcNtaps(addrWidth);

    logic [dataWidth-1:0] r_mem [NTAPS];

    // Store an incoming coefficient word at its staging slot.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/coeff_bank_loader.sv
// Coefficient bank writer: collects a complete coefficient set into local
// staging, then streams it to the filter's write port in one burst so a
// partial or aborted set never reaches the live bank.
module coeff_bank_loader
    import coeff_bank_loader_pkg::*;
#(
    parameter int unsigned addrWidth = DEF_ADDR_WIDTH,
    parameter int unsigned dataWidth = DEF_DATA_WIDTH
) (
    input  logic                 Clk_i,
    input  logic                 Rst_i,
    input  logic                 Sym_i,
    input  logic [dataWidth-1:0] Coeff_i,
    input  logic                 CoeffValid_i,
    input  logic                 CoeffFirst_i,
    output logic                 CoeffReady_o,
    output logic [addrWidth-1:0] CoeffAddr_o,
    output logic [dataWidth-1:0] CoeffData_o,
    output logic                 CoeffWr_o,
    output logic                 Busy_o,
    output logic                 Done_o,
    output logic                 Err_o
);

    localparam int unsigned      NTAPS   = calcNtaps(addrWidth);
    localparam logic [addrWidth:0] NTAPS_C = (addrWidth+1)'(NTAPS);
    localparam logic [addrWidth:0] HALF_C  = (addrWidth+1)'(NTAPS / 2);
    localparam logic [addrWidth:0] ONE_C   = (addrWidth+1)'(1);

    state_t               r_state;
    state_t               w_nextState;

    logic [addrWidth:0]   r_count;
    logic [addrWidth:0]   r_commitIdx;
    logic                 r_sym;
    logic                 r_ready;
    logic [addrWidth-1:0] r_addr;
    logic [dataWidth-1:0] r_data;
    logic                 r_wr;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic [addrWidth:0]   w_nextCount;
    logic [addrWidth:0]   w_nextCommitIdx;
    logic                 w_nextSym;
    logic                 w_nextReady;
    logic [addrWidth-1:0] w_nextAddr;
    logic [dataWidth-1:0] w_nextData;
    logic                 w_nextWr;
    logic                 w_nextBusy;
    logic                 w_nextDone;
    logic                 w_nextErr;

    logic                 w_accept;
    logic [addrWidth:0]   w_expected;
    logic [addrWidth:0]   w_countInc;
    logic                 w_lastWord;
    logic                 w_stageWe;
    logic [addrWidth-1:0] w_stageAddr;
    logic [addrWidth-1:0] w_mirrorAddr;
    logic [addrWidth-1:0] w_rdAddr;
    logic [dataWidth-1:0] w_rdData;

    // A word moves only when the registered ready is high; the set length
    // halves in symmetric mode because the upper half is mirrored on commit.
    assign w_accept     = CoeffValid_i & r_ready;
    assign w_expected   = r_sym ? HALF_C : NTAPS_C;
    assign w_countInc   = r_count + ONE_C;
    assign w_lastWord   = (r_state == COLLECT) && w_accept && !CoeffFirst_i &&
                          (w_countInc == w_expected);
    assign w_mirrorAddr = addrWidth'(mirrorIdx(addrWidth, 32'(r_commitIdx)));
    assign w_rdAddr     = (r_sym && (r_commitIdx >= HALF_C)) ? w_mirrorAddr
                                                            : r_commitIdx[addrWidth-1:0];

    coeff_stage_regs #(
        .addrWidth (addrWidth),
        .dataWidth (dataWidth)
    ) u_stage (
        .i_clk    (Clk_i),
        .i_wrEn   (w_stageWe),
        .i_wrAddr (w_stageAddr),
        .i_wrData (Coeff_i),
        .i_rdAddr (w_rdAddr),
        .o_rdData (w_rdData)
    );

    // FSM state register.
    always_ff @(posedge Clk_i) begin
        if (!Rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state decision.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && CoeffFirst_i) begin
                    w_nextState = COLLECT;
                end
            end
            COLLECT: begin
                if (w_lastWord) begin
                    w_nextState = COMMIT;
                end
            end
            COMMIT: begin
                if (r_commitIdx == NTAPS_C) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // FSM outputs: staging writes, counters and next values of the output registers.
    always_comb begin
        w_nextCount     = r_count;
        w_nextCommitIdx = r_commitIdx;
        w_nextSym       = r_sym;
        w_nextAddr      = r_addr;
        w_nextData      = r_data;
        w_nextWr        = 1'b0;
        w_nextDone      = 1'b0;
        w_nextErr       = 1'b0;
        w_stageWe       = 1'b0;
        w_stageAddr     = r_count[addrWidth-1:0];
        w_nextReady     = (w_nextState != COMMIT);
        w_nextBusy      = (w_nextState != IDLE);
        case (r_state)
            IDLE: begin
                w_nextCommitIdx = '0;
                if (w_accept) begin
                    if (CoeffFirst_i) begin
                        w_stageWe   = 1'b1;
                        w_stageAddr = '0;
                        w_nextSym   = Sym_i;
                        w_nextCount = ONE_C;
                    end else begin
                        w_nextErr   = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (w_accept) begin
                    w_stageWe = 1'b1;
                    if (CoeffFirst_i) begin
                        w_nextErr   = 1'b1;
                        w_stageAddr = '0;
                        w_nextSym   = Sym_i;
                        w_nextCount = ONE_C;
                    end else begin
                        w_nextCount = w_countInc;
                    end
                end
                if (w_lastWord) begin
                    w_nextWr        = 1'b1;
                    w_nextAddr      = '0;
                    w_nextData      = w_rdData;
                    w_nextCommitIdx = ONE_C;
                end
            end
            COMMIT: begin
                if (r_commitIdx == NTAPS_C) begin
                    w_nextDone      = 1'b1;
                    w_nextCommitIdx = '0;
                    w_nextCount     = '0;
                end else begin
                    w_nextWr        = 1'b1;
                    w_nextAddr      = r_commitIdx[addrWidth-1:0];
                    w_nextData      = w_rdData;
                    w_nextCommitIdx = r_commitIdx + ONE_C;
                end
            end
            default: begin
                w_nextCommitIdx = '0;
            end
        endcase
    end

    // Counters and registered outputs.
    always_ff @(posedge Clk_i) begin
        if (!Rst_i) begin
            r_count     <= '0;
            r_commitIdx <= '0;
            r_sym       <= 1'b0;
            r_ready     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_wr        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_count     <= w_nextCount;
            r_commitIdx <= w_nextCommitIdx;
            r_sym       <= w_nextSym;
            r_ready     <= w_nextReady;
            r_addr      <= w_nextAddr;
            r_data      <= w_nextData;
            r_wr        <= w_nextWr;
            r_busy      <= w_nextBusy;
            r_done      <= w_nextDone;
            r_err       <= w_nextErr;
        end
    end

    assign CoeffReady_o = r_ready;
    assign CoeffAddr_o  = r_addr;
    assign CoeffData_o  = r_data;
    assign CoeffWr_o    = r_wr;
    assign Busy_o       = r_busy;
    assign Done_o       = r_done;
    assign Err_o        = r_err;

endmodule
